if_prefetch_unit: RTL and testbench

Parametrised instruction-fetch stage with a DEPTH-entry prefetch queue between the instruction memory (IM) and the IF/ID register. It issues sequential fetch requests ahead of decode, tolerates multi-cycle in-order IM responses, and keeps fetching while decode is stalled. On a branch/jump redirect from ID it keeps the delay-slot instruction, flushes the queue and discards stale in-flight responses.

---
 rtl/if_pkg.sv | 13 +
 rtl/if_prefetch_unit_if.sv | 31 +++
 rtl/if_prefetch_fifo.sv | 60 ++++++
 rtl/if_prefetch_unit.sv | 104 ++++++++++
 tb/tb_if_prefetch_unit.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared defaults and helpers for the instruction-fetch prefetch unit.
// Counter width covers 0..DEPTH inclusive.
package if_pkg;

   localparam logic [31:0] RESET_VECTOR_DEF = 32'hBFC00000;
   localparam int          INCR_DEF         = 4;
   localparam logic [31:0] NOP              = 32'h0;

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Bus bundle between the fetch unit, the instruction memory and the ID stage.
// The master modport is the fetch unit; the slave modport is its environment.
interface if_prefetch_unit_if #(
   parameter int ADDR_W  = 32,
   parameter int INSTR_W = 32
);
   logic               STALL;
   logic [ADDR_W-1:0]  AltPC_IN;
   logic               AltPCEnable_IN;
   logic [ADDR_W-1:0]  InstructionAddress_OUT;
   logic               IMReq_OUT;
   logic               IMReady_IN;
   logic               IMValid_IN;
   logic [INSTR_W-1:0] Instruction_IN;
   logic               Valid_OUT;
   logic [INSTR_W-1:0] Instruction_OUT;
   logic [ADDR_W-1:0]  InstructionAddressPlus4_OUT;

   modport master (
      input  STALL, AltPC_IN, AltPCEnable_IN, IMReady_IN, IMValid_IN, Instruction_IN,
      output InstructionAddress_OUT, IMReq_OUT, Valid_OUT, Instruction_OUT,
             InstructionAddressPlus4_OUT
   );

   modport slave (
      output STALL, AltPC_IN, AltPCEnable_IN, IMReady_IN, IMValid_IN, Instruction_IN,
      input  InstructionAddress_OUT, IMReq_OUT, Valid_OUT, Instruction_OUT,
             InstructionAddressPlus4_OUT
   );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous FIFO with a single-cycle flush. The head stays readable in the
// flush cycle, so a pop coinciding with a flush still delivers its entry.
module if_prefetch_fifo
   import if_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int CW = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head_data,
   output logic [CW-1:0]    count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic [CW-1:0]    cnt;
   logic             do_pop;
   logic             do_push;

   assign do_pop  = pop && (cnt != '0);
   assign do_push = push && !flush && ((cnt != CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // DEPTH is a power of two, so the pointers wrap naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   assign head_data = mem[rd_ptr];
   assign count     = cnt;

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue, in-order IM
// responses, and redirect handling that keeps the delay slot and drops stale data.
module if_prefetch_unit
   import if_pkg::*;
#(
   parameter int                ADDR_W       = 32,
   parameter int                INSTR_W      = 32,
   parameter int                DEPTH        = 4,
   parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
   parameter int                INCR         = INCR_DEF
) (
   input  logic               CLOCK,
   input  logic               RESET,
   if_prefetch_unit_if.master bus
);

   localparam int CW = cnt_w(DEPTH);

   logic [ADDR_W-1:0]         pc;
   logic [CW-1:0]             occ;
   logic [CW-1:0]             outst;
   logic [CW-1:0]             outst_nxt;
   logic [CW-1:0]             squash;
   logic [CW-1:0]             squash_nxt;
   logic [CW:0]               credit_used;
   logic                      issue;
   logic                      resp;
   logic                      enq;
   logic                      pop;
   logic                      redirect;
   logic [ADDR_W-1:0]         tag_head;
   logic [INSTR_W+ADDR_W-1:0] q_head;
   logic [INSTR_W-1:0]        q_instr;
   logic [ADDR_W-1:0]         q_plus;

   // Credits count both queued entries and requests still in flight
   assign credit_used   = (CW+1)'(occ) + (CW+1)'(outst);
   assign bus.IMReq_OUT = credit_used < (CW+1)'(DEPTH);

   assign issue    = bus.IMReq_OUT && bus.IMReady_IN;
   assign resp     = bus.IMValid_IN && (outst != '0);
   assign redirect = bus.AltPCEnable_IN;
   assign enq      = resp && (squash == '0) && !redirect;
   assign pop      = (occ != '0) && !bus.STALL;

   always_comb begin
      outst_nxt = outst;
      if (issue && !resp)      outst_nxt = outst + CW'(1);
      else if (!issue && resp) outst_nxt = outst - CW'(1);

      // Every request still unanswered after a redirect belongs to the old stream
      squash_nxt = squash;
      if (redirect)                   squash_nxt = outst_nxt;
      else if (resp && squash != '0)  squash_nxt = squash - CW'(1);
   end

   always_ff @(posedge CLOCK or negedge RESET) begin
      if (!RESET) begin
         pc     <= RESET_VECTOR;
         squash <= '0;
      end else begin
         squash <= squash_nxt;
         if (redirect)   pc <= bus.AltPC_IN;
         else if (issue) pc <= pc + ADDR_W'(INCR);
      end
   end

   // The tag queue's occupancy is the outstanding-request count
   if_prefetch_fifo #(
      .WIDTH (ADDR_W),
      .DEPTH (DEPTH)
   ) u_tag_q (
      .clk       (CLOCK),
      .rst_n     (RESET),
      .push      (issue),
      .push_data (pc),
      .pop       (resp),
      .flush     (1'b0),
      .head_data (tag_head),
      .count     (outst)
   );

   if_prefetch_fifo #(
      .WIDTH (INSTR_W + ADDR_W),
      .DEPTH (DEPTH)
   ) u_instr_q (
      .clk       (CLOCK),
      .rst_n     (RESET),
      .push      (enq),
      .push_data ({bus.Instruction_IN, tag_head + ADDR_W'(INCR)}),
      .pop       (pop),
      .flush     (redirect),
      .head_data (q_head),
      .count     (occ)
   );

   assign {q_instr, q_plus} = q_head;

   assign bus.InstructionAddress_OUT      = pc;
   assign bus.Valid_OUT                   = (occ != '0);
   assign bus.Instruction_OUT             = bus.Valid_OUT ? q_instr : INSTR_W'(NOP);
   assign bus.InstructionAddressPlus4_OUT = bus.Valid_OUT ? q_plus : '0;

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Randomized scoreboard bench: expected delivery stream derived from PC-order
// and redirect rules, compared against every pop the fetch unit presents.
module tb_if_prefetch_unit;
   import if_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int INSTR_W = 32;
   localparam int DEPTH   = 4;

   logic CLOCK = 1'b0;
   logic RESET = 1'b0;
   always #5 CLOCK = ~CLOCK;

   if_prefetch_unit_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   if_prefetch_unit #(
      .ADDR_W  (ADDR_W),
      .INSTR_W (INSTR_W),
      .DEPTH   (DEPTH)
   ) dut (
      .CLOCK (CLOCK),
      .RESET (RESET),
      .bus   (bus)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } req_t;

   req_t        im_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] exp_pc;
   logic [31:0] mon_a;
   req_t        new_req;
   int          tests     = 0;
   int          fails     = 0;
   int          cyc       = 0;
   int          max_lat   = 0;
   int          issue_cnt = 0;
   int          pop_cnt   = 0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h13579BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic refill();
      while (exp_q.size() < 8) begin
         exp_q.push_back(exp_pc);
         exp_pc = exp_pc + 32'd4;
      end
   endtask

   always @(posedge CLOCK) cyc <= cyc + 1;

   // Instruction memory: in-order, variable latency, at least one cycle
   always @(negedge CLOCK) begin
      if (RESET) begin
         if (bus.IMValid_IN && im_q.size() > 0) void'(im_q.pop_front());
         if (bus.IMReq_OUT && bus.IMReady_IN) begin
            new_req.addr = bus.InstructionAddress_OUT;
            new_req.due  = cyc + 1 + int'($urandom_range(0, max_lat));
            im_q.push_back(new_req);
            issue_cnt++;
         end
      end
   end

   // Monitor: every pop is checked against the head of the expected stream
   always @(negedge CLOCK) begin
      if (RESET) begin
         if (!bus.Valid_OUT) begin
            chk("idle_instr", bus.Instruction_OUT, 32'h0);
            chk("idle_plus", bus.InstructionAddressPlus4_OUT, 32'h0);
         end else if (!bus.STALL) begin
            pop_cnt++;
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL sb_underflow: got plus %h expected none", bus.InstructionAddressPlus4_OUT);
            end else begin
               mon_a = exp_q.pop_front();
               chk("pop_plus", bus.InstructionAddressPlus4_OUT, mon_a + 32'd4);
               chk("pop_instr", bus.Instruction_OUT, mem_word(mon_a));
            end
         end
      end
   end

   task automatic step(input bit stall, input bit ready, input bit redir, input logic [31:0] tgt);
      @(posedge CLOCK);
      #1;
      bus.STALL          = stall;
      bus.IMReady_IN     = ready;
      bus.AltPCEnable_IN = redir;
      bus.AltPC_IN       = tgt;
      if (im_q.size() > 0 && im_q[0].due <= cyc) begin
         bus.IMValid_IN     = 1'b1;
         bus.Instruction_IN = mem_word(im_q[0].addr);
      end else begin
         bus.IMValid_IN     = 1'b0;
         bus.Instruction_IN = $urandom;
      end
      @(negedge CLOCK);
      #1;
      if (redir) begin
         exp_q.delete();
         exp_pc = tgt;
      end
      refill();
   endtask

   task automatic apply_reset();
      RESET              = 1'b0;
      bus.STALL          = 1'b0;
      bus.IMReady_IN     = 1'b0;
      bus.AltPCEnable_IN = 1'b0;
      bus.AltPC_IN       = 32'h0;
      bus.IMValid_IN     = 1'b0;
      bus.Instruction_IN = 32'h0;
      im_q.delete();
      exp_q.delete();
      exp_pc = RESET_VECTOR_DEF;
      refill();
      repeat (2) @(negedge CLOCK);
      RESET = 1'b1;
   endtask

   initial begin
      apply_reset();
      chk("rst_valid", {31'h0, bus.Valid_OUT}, 32'h0);
      chk("rst_instr", bus.Instruction_OUT, 32'h0);
      chk("rst_plus", bus.InstructionAddressPlus4_OUT, 32'h0);
      chk("rst_addr", bus.InstructionAddress_OUT, 32'hBFC00000);
      chk("rst_req", {31'h0, bus.IMReq_OUT}, 32'h1);

      // Stalled decode: exactly DEPTH fetches, then the request drops
      issue_cnt = 0;
      max_lat   = 0;
      repeat (10) step(1'b1, 1'b1, 1'b0, 32'h0);
      chk("stall_issues", issue_cnt, DEPTH);
      chk("stall_req", {31'h0, bus.IMReq_OUT}, 32'h0);
      repeat (20) step(1'b0, 1'b1, 1'b0, 32'h0);

      // Directed redirects: stalled, back-to-back, then sequential wrap
      step(1'b1, 1'b1, 1'b1, 32'h00400020);
      repeat (6) step(1'b0, 1'b1, 1'b0, 32'h0);
      step(1'b0, 1'b1, 1'b1, 32'h00500000);
      step(1'b0, 1'b1, 1'b1, 32'h00600000);
      repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);

      apply_reset();
      step(1'b0, 1'b1, 1'b1, 32'hFFFFFFF8);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_a0", bus.InstructionAddress_OUT, 32'hFFFFFFF8);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_a1", bus.InstructionAddress_OUT, 32'hFFFFFFFC);
      step(1'b0, 1'b1, 1'b0, 32'h0);
      chk("wrap_a2", bus.InstructionAddress_OUT, 32'h00000000);
      repeat (8) step(1'b0, 1'b1, 1'b0, 32'h0);

      for (int i = 0; i < 3000; i++) begin
         max_lat = (i / 500) % 4;
         step($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 7,
              $urandom_range(0, 99) < 6, $urandom & 32'hFFFFFFFC);
         if (i == 1500) begin
            #2;
            RESET = 1'b0;
            #1;
            chk("async_valid", {31'h0, bus.Valid_OUT}, 32'h0);
            chk("async_addr", bus.InstructionAddress_OUT, 32'hBFC00000);
            chk("async_req", {31'h0, bus.IMReq_OUT}, 32'h1);
            apply_reset();
         end
      end
      repeat (12) step(1'b0, 1'b1, 1'b0, 32'h0);

      chk("progress", {31'h0, pop_cnt > 500}, 32'h1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
